// File: rtl/zynq_rst_pkg.sv
// Shared definitions for the Zynq reset/power sequencer.
//   seq_state_t      : sequencer FSM states
//   seq_out_t        : registered output levels driven by each state
//   CAUSE_*          : bit positions inside rst_cause
//   DEF_*_TICKS      : default hold times in slow (10 Hz) ticks
//   decode_outputs() : Moore decode of a state into its output levels
package zynq_rst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PWR_OFF   = 2'd1,
    ST_POR_HOLD  = 2'd2,
    ST_SRST_HOLD = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic rail;
    logic por_n;
    logic srst_n;
    logic busy;
  } seq_out_t;

  localparam int CAUSE_WDOG_PC = 0;  // power cycle requested by a watchdog timeout
  localparam int CAUSE_WARM    = 1;  // warm reset
  localparam int CAUSE_EXT_PC  = 2;  // power cycle not caused by a timeout

  localparam int DEF_OFF_TICKS  = 20;
  localparam int DEF_POR_TICKS  = 5;
  localparam int DEF_SRST_TICKS = 2;

  localparam int CNT_W = 8;

  function automatic seq_out_t decode_outputs(input seq_state_t s);
    seq_out_t o;
    case (s)
      ST_IDLE:      o = '{rail: 1'b1, por_n: 1'b1, srst_n: 1'b1, busy: 1'b0};
      ST_PWR_OFF:   o = '{rail: 1'b0, por_n: 1'b0, srst_n: 1'b0, busy: 1'b1};
      ST_POR_HOLD:  o = '{rail: 1'b1, por_n: 1'b0, srst_n: 1'b0, busy: 1'b1};
      default:      o = '{rail: 1'b1, por_n: 1'b1, srst_n: 1'b0, busy: 1'b1};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/zynq_rst_seq_slow_tick_det.sv
// slow_tick_det: brings the free-running slow square wave into the clk domain
// and turns each of its rising edges into a single-cycle tick.
//   clk, rst : system clock, synchronous active-high reset
//   slow_in  : asynchronous slow square wave
//   tick     : one-cycle pulse, high 3 clk edges after slow_in rises
module slow_tick_det (
  input  logic clk,
  input  logic rst,
  input  logic slow_in,
  output logic tick
);

  logic sync_p0, sync_p1, prev_p2;

  // Two-flop synchronizer, history flop, registered edge pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      tick    <= 1'b0;
    end else begin
      sync_p0 <= slow_in;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      tick    <= sync_p1 & ~prev_p2;
    end
  end

endmodule

// File: rtl/zynq_rst_seq.sv
// zynq_rst_seq: sequences the Zynq core rail, PS POR and PS SRST in response
// to watchdog requests, timing each phase in 10 Hz ticks.
//   clk, rst             : system clock, synchronous active-high reset
//   clk_10hz_fp          : asynchronous slow square wave (tick source)
//   zynq_power_cycle_en  : level request for a full power cycle (edge-triggered)
//   warm_reset_out       : level request for a warm reset (edge-triggered)
//   zynq_wdog_timeout    : current request originates from a watchdog timeout
//   cause_clr            : pulse clearing rst_cause
//   pwr_rail_en          : core rail enable (1 = on)
//   zynq_por_n           : PS power-on reset, active-low
//   zynq_srst_n          : PS system reset, active-low
//   seq_busy             : high whenever the sequencer is not idle
//   rst_cause            : sticky cause bits {ext pc, warm, wdog pc}
//   boot_cnt             : completed sequences, saturating at 255
// Optional feature macro: ZYNQ_RST_SEQ_CAUSE_EN builds the rst_cause register;
// without it rst_cause reads 0 and cause_clr is ignored.
module zynq_rst_seq
  import zynq_rst_pkg::*;
#(
  parameter int OFF_TICKS  = DEF_OFF_TICKS,
  parameter int POR_TICKS  = DEF_POR_TICKS,
  parameter int SRST_TICKS = DEF_SRST_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_10hz_fp,
  input  logic       zynq_power_cycle_en,
  input  logic       warm_reset_out,
  input  logic       zynq_wdog_timeout,
  input  logic       cause_clr,
  output logic       pwr_rail_en,
  output logic       zynq_por_n,
  output logic       zynq_srst_n,
  output logic       seq_busy,
  output logic [2:0] rst_cause,
  output logic [7:0] boot_cnt
);

  localparam logic [CNT_W-1:0] OFF_LD  = CNT_W'(OFF_TICKS);
  localparam logic [CNT_W-1:0] POR_LD  = CNT_W'(POR_TICKS);
  localparam logic [CNT_W-1:0] SRST_LD = CNT_W'(SRST_TICKS);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             pc_q, wr_q;
  logic             pc_edge, wr_edge;
  logic             go_off, go_warm;

  slow_tick_det u_tick (
    .clk     (clk),
    .rst     (rst),
    .slow_in (clk_10hz_fp),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      pc_q <= zynq_power_cycle_en;
      wr_q <= warm_reset_out;
    end
  end

  assign pc_edge = zynq_power_cycle_en & ~pc_q;
  assign wr_edge = warm_reset_out & ~wr_q;

  // Power cycle beats a simultaneous warm request and may preempt a warm reset
  assign go_off  = pc_edge && (state == ST_IDLE || state == ST_SRST_HOLD);
  assign go_warm = wr_edge && !pc_edge && (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_POR_HOLD;
      cnt      <= POR_LD;
      {pwr_rail_en, zynq_por_n, zynq_srst_n, seq_busy} <= decode_outputs(ST_POR_HOLD);
      boot_cnt <= 8'd0;
    end else if (go_off) begin
      state <= ST_PWR_OFF;
      cnt   <= OFF_LD;
      {pwr_rail_en, zynq_por_n, zynq_srst_n, seq_busy} <= decode_outputs(ST_PWR_OFF);
    end else if (go_warm) begin
      state <= ST_SRST_HOLD;
      cnt   <= SRST_LD;
      {pwr_rail_en, zynq_por_n, zynq_srst_n, seq_busy} <= decode_outputs(ST_SRST_HOLD);
    end else if (tick && state != ST_IDLE) begin
      // Counter reaches its last tick: leave the timed state
      if (cnt <= CNT_W'(1)) begin
        if (state == ST_PWR_OFF) begin
          state <= ST_POR_HOLD;
          cnt   <= POR_LD;
          {pwr_rail_en, zynq_por_n, zynq_srst_n, seq_busy} <= decode_outputs(ST_POR_HOLD);
        end else begin
          state    <= ST_IDLE;
          boot_cnt <= sat_inc(boot_cnt);
          {pwr_rail_en, zynq_por_n, zynq_srst_n, seq_busy} <= decode_outputs(ST_IDLE);
        end
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

`ifdef ZYNQ_RST_SEQ_CAUSE_EN
  logic [2:0] cause_r, cause_set;

  always_comb begin
    cause_set = '0;
    if (go_off) begin
      if (zynq_wdog_timeout) cause_set[CAUSE_WDOG_PC] = 1'b1;
      else                   cause_set[CAUSE_EXT_PC]  = 1'b1;
    end
    if (go_warm) cause_set[CAUSE_WARM] = 1'b1;
  end

  // A set in the same cycle as a clear survives the clear
  always_ff @(posedge clk) begin
    if (rst) cause_r <= '0;
    else     cause_r <= (cause_clr ? 3'b000 : cause_r) | cause_set;
  end

  assign rst_cause = cause_r;
`else
  logic unused_cause_inputs;
  assign unused_cause_inputs = cause_clr ^ zynq_wdog_timeout;
  assign rst_cause = 3'b000;
`endif

endmodule

// File: doc/zynq_rst_seq.md
ZYNQ_RST_SEQ -- requirements
Module: zynq_rst_seq

Interface
REQ-001 SHALL have parameter OFF_TICKS, default 20, rail-off time in slow ticks (2 s at 10 Hz); legal range 1..255.
REQ-002 SHALL have parameter POR_TICKS, default 5, POR hold time in slow ticks; legal range 1..255.
REQ-003 SHALL have parameter SRST_TICKS, default 2, warm-reset hold time in slow ticks; legal range 1..255.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk and rst.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 clk_10hz_fp  input  1  free-running slow square wave; asynchronous to clk.
REQ-008 zynq_power_cycle_en  input  1  level request from the watchdog for a full power cycle.
REQ-009 warm_reset_out  input  1  level request from the watchdog for a warm reset.
REQ-010 zynq_wdog_timeout  input  1  level flag from the watchdog: the current request comes from a timeout.
REQ-011 cause_clr  input  1  one-cycle pulse that clears rst_cause.
REQ-012 pwr_rail_en  output  1  Zynq core rail enable, 1 = on.
REQ-013 zynq_por_n  output  1  PS power-on reset, active-low.
REQ-014 zynq_srst_n  output  1  PS system reset, active-low.
REQ-015 seq_busy  output  1  high in every state except IDLE.
REQ-016 rst_cause  output  3  sticky cause bits: [0] wdog power cycle, [1] warm reset, [2] non-wdog power cycle.
REQ-017 boot_cnt  output  8  completed sequences, saturating.

Function
REQ-018 Tick path SHALL be a 2-flop synchronizer on clk_10hz_fp plus a rising-edge detector; a one-cycle tick SHALL occur 3 clk edges after the input rises.
REQ-019 FSM states SHALL be IDLE, PWR_OFF, POR_HOLD and SRST_HOLD; outputs SHALL be registered Moore decodes valid in the cycle the state register changes.
REQ-020 Output levels (rail/por_n/srst_n) SHALL be: IDLE 1/1/1; PWR_OFF 0/0/0; POR_HOLD 1/0/0; SRST_HOLD 1/1/0.
REQ-021 Requests SHALL be edge-triggered: rising edges of zynq_power_cycle_en and warm_reset_out, detected against a registered copy of each input.
REQ-022 In IDLE: a power-cycle edge -> PWR_OFF; a warm-reset edge -> SRST_HOLD. The state SHALL change on the clk edge after the cycle in which the request edge is sampled.
REQ-023 When both request edges occur in the same cycle, power cycle SHALL win; the warm request SHALL be dropped.
REQ-024 A power-cycle edge during SRST_HOLD SHALL preempt it: -> PWR_OFF with the tick counter reloaded. All other request edges outside IDLE SHALL be ignored.
REQ-025 Each timed state SHALL load its tick count on entry and exit on the Nth tick after entry: PWR_OFF -> POR_HOLD; POR_HOLD -> IDLE; SRST_HOLD -> IDLE.
REQ-026 A tick in the entry cycle SHALL NOT count.
REQ-027 On entry to PWR_OFF, rst_cause[0] SHALL be set if zynq_wdog_timeout=1, else rst_cause[2] SHALL be set. On entry to SRST_HOLD, rst_cause[1] SHALL be set.
REQ-028 cause_clr SHALL clear all rst_cause bits; when set and clear coincide, set SHALL win.
REQ-029 boot_cnt SHALL increment by 1 on each transition into IDLE and saturate at 255.

Reset
REQ-030 rst SHALL force state POR_HOLD with the counter loaded to POR_TICKS; pwr_rail_en=1, zynq_por_n=0, zynq_srst_n=0, seq_busy=1, rst_cause=0, boot_cnt=0, synchronizer and edge-detect flops cleared.
REQ-031 rst asserted mid-sequence SHALL abort the sequence immediately with no pass through IDLE.
REQ-032 The first release after reset SHALL increment boot_cnt to 1.

Configuration
REQ-033 Macro ZYNQ_RST_SEQ_CAUSE_EN, when defined, SHALL compile in the rst_cause register and the cause_clr logic.
REQ-034 Without ZYNQ_RST_SEQ_CAUSE_EN, rst_cause SHALL be tied to 0 and cause_clr SHALL be ignored; all other behaviour SHALL be unchanged.

Structure
REQ-035 Package zynq_rst_pkg SHALL hold the state enum, the cause bit index constants and the default tick constants.
REQ-036 Sub-module slow_tick_det SHALL contain the synchronizer and edge detector and output the one-cycle tick.

Verification (clk 8 ns, clk_10hz_fp 100 ns; OFF_TICKS=3, POR_TICKS=2, SRST_TICKS=1)
REQ-037 Reset release -> POR_HOLD for 2 ticks, then IDLE with 1/1/1 outputs, seq_busy=0, boot_cnt=1.
REQ-038 Power-cycle edge with zynq_wdog_timeout=1 -> rail off for 3 ticks, POR for 2 ticks, then IDLE; rst_cause=3'b001, boot_cnt=2.
REQ-039 Warm-reset edge -> srst_n low for 1 tick, rail and por_n stay high; rst_cause[1]=1.
REQ-040 Power-cycle and warm edges in the same cycle -> PWR_OFF only; rst_cause[1] stays 0.
REQ-041 Power-cycle edge during SRST_HOLD -> PWR_OFF on the next edge; full 3-tick off period.
REQ-042 rst pulsed during PWR_OFF -> next cycle POR_HOLD with rail=1 and rst_cause=0; a held-high request does not retrigger without a new edge.
